// File: rtl/minimal_nios2_qsys_0_oci_dct_packer.sv
// OCI DCT trace packer: packs 2-bit branch records into 30-bit words behind a valid/ready handshake.
// Optional DCT_IDLE_FLUSH_EN adds an idle-timeout flush of partial words.
module minimal_nios2_qsys_0_oci_dct_packer #(
  parameter int RECS_PER_WORD = 15,
  parameter int DROP_CNT_W    = 8,
  parameter int IDLE_TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rec_valid,
  input  logic [1:0]                 rec_code,
  input  logic                       flush,
  output logic [2*RECS_PER_WORD-1:0] dct_buffer,
  output logic [3:0]                 dct_count,
  output logic                       dct_valid,
  input  logic                       dct_ready,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  input  logic                       drop_clr
);
  localparam int BUF_W = 2*RECS_PER_WORD;
  localparam logic [3:0] FULL_CNT = 4'(RECS_PER_WORD);

  typedef enum logic [1:0] {FILL, FULL_WAIT, STALL} state_t;
  state_t state, state_nxt;

  logic [BUF_W-1:0] acc, acc_ins;
  logic [3:0]       acc_count, cnt_ins;
  logic             flush_lat, idle_flush, flush_req;
  logic             room, take, want, out_free, xfer, drop, carry;

  assign room      = acc_count < FULL_CNT;
  assign take      = rec_valid && room;
  assign cnt_ins   = acc_count + {3'b0, take};
  assign flush_req = flush || flush_lat || idle_flush;
  // A full accumulator always wants out; a partial one only on a flush request.
  assign want      = (cnt_ins == FULL_CNT) || (flush_req && cnt_ins != 4'd0);
  assign out_free  = !dct_valid || dct_ready;
  assign xfer      = want && out_free;
  assign drop      = rec_valid && !room && !xfer;
  // Record arriving while a full accumulator leaves becomes record 0 of the next word.
  assign carry     = rec_valid && !room && xfer;
  assign dct_valid = (state != FILL);

  always_comb begin
    acc_ins = acc;
    if (take) acc_ins[{acc_count, 1'b0} +: 2] = rec_code;
  end

  always_comb begin
    state_nxt = state;
    if (xfer)                 state_nxt = FULL_WAIT;
    else if (out_free)        state_nxt = FILL;
    else if (cnt_ins == FULL_CNT) state_nxt = STALL;
    else                      state_nxt = FULL_WAIT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FILL;
      acc        <= '0;
      acc_count  <= '0;
      flush_lat  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        acc        <= carry ? BUF_W'(rec_code) : '0;
        acc_count  <= carry ? 4'd1 : 4'd0;
        flush_lat  <= 1'b0;
        dct_buffer <= acc_ins;
        dct_count  <= cnt_ins;
      end else begin
        acc       <= acc_ins;
        acc_count <= cnt_ins;
        if ((flush || idle_flush) && cnt_ins != 4'd0) flush_lat <= 1'b1;
        if (dct_valid && dct_ready) begin
          dct_buffer <= '0;
          dct_count  <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    drop_cnt <= '0;
    else if (drop_clr)               drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end

`ifdef DCT_IDLE_FLUSH_EN
  logic [6:0] idle_cnt;
  assign idle_flush = (idle_cnt == 7'(IDLE_TIMEOUT));

  // Holds at the timeout value so a flush latched behind a busy output is not re-armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   idle_cnt <= '0;
    else if (rec_valid || xfer || acc_count == 4'd0) idle_cnt <= '0;
    else if (!idle_flush)                           idle_cnt <= idle_cnt + 7'd1;
  end
`else
  assign idle_flush = 1'b0;
`endif

endmodule

// File: tb/tb_minimal_nios2_qsys_0_oci_dct_packer.sv
// Directed self-checking bench for the DCT packer (default build, idle flush disabled).
module tb_minimal_nios2_qsys_0_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rec_valid = 1'b0;
  logic [1:0]  rec_code = 2'b00;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic [7:0]  drop_cnt;
  logic        drop_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  minimal_nios2_qsys_0_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .rec_valid(rec_valid), .rec_code(rec_code),
    .flush(flush), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .drop_cnt(drop_cnt),
    .drop_clr(drop_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, clock, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] c, input logic f,
                      input logic r, input logic clr);
    rec_valid = v; rec_code = c; flush = f; dct_ready = r; drop_clr = clr;
    @(posedge clk);
    #1;
    rec_valid = 1'b0; flush = 1'b0; drop_clr = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_valid", 32'(dct_valid), 32'd0);
    chk("rst_count", 32'(dct_count), 32'd0);
    chk("rst_buf",   32'(dct_buffer), 32'd0);
    chk("rst_drop",  32'(drop_cnt), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // 15 taken records, consumer always ready
    for (int i = 0; i < 14; i++) step(1, 2'b01, 0, 1, 0);
    chk("full14_valid", 32'(dct_valid), 32'd0);
    step(1, 2'b01, 0, 1, 0);
    chk("full15_valid", 32'(dct_valid), 32'd1);
    chk("full15_count", 32'(dct_count), 32'd15);
    chk("full15_buf",   32'(dct_buffer), 32'h15555555);
    step(0, 2'b00, 0, 1, 0);
    chk("full15_taken", 32'(dct_valid), 32'd0);

    // partial word via flush: records 11,01,10 -> 0x27
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    chk("part_noflush", 32'(dct_valid), 32'd0);
    step(0, 2'b00, 1, 0, 0);
    chk("part_valid", 32'(dct_valid), 32'd1);
    chk("part_count", 32'(dct_count), 32'd3);
    chk("part_buf",   32'(dct_buffer), 32'h27);
    step(0, 2'b00, 0, 1, 0);
    chk("part_taken", 32'(dct_valid), 32'd0);
    step(0, 2'b00, 1, 1, 0);
    chk("empty_flush", 32'(dct_valid), 32'd0);
    step(1, 2'b01, 0, 1, 0);
    chk("flush_not_latched", 32'(dct_valid), 32'd0);
    step(0, 2'b00, 1, 1, 0);
    chk("fresh_count", 32'(dct_count), 32'd1);
    chk("fresh_buf",   32'(dct_buffer), 32'h1);
    step(0, 2'b00, 0, 1, 0);

    // back-pressure: 31 records of 00, one drop
    for (int i = 0; i < 15; i++) step(1, 2'b00, 0, 0, 0);
    chk("bp_w1_valid", 32'(dct_valid), 32'd1);
    chk("bp_w1_count", 32'(dct_count), 32'd15);
    for (int i = 0; i < 15; i++) step(1, 2'b00, 0, 0, 0);
    chk("bp_30_drop", 32'(drop_cnt), 32'd0);
    step(1, 2'b00, 0, 0, 0);
    chk("bp_31_drop",  32'(drop_cnt), 32'd1);
    chk("bp_31_count", 32'(dct_count), 32'd15);
    chk("bp_31_buf",   32'(dct_buffer), 32'd0);
    step(1, 2'b00, 0, 0, 1);
    chk("clr_priority", 32'(drop_cnt), 32'd0);
    step(1, 2'b00, 0, 0, 0);
    chk("drop_again", 32'(drop_cnt), 32'd1);
    // release with a same-cycle record: word 2 moves out, record 11 starts word 3
    step(1, 2'b11, 0, 1, 0);
    chk("bp_w2_valid", 32'(dct_valid), 32'd1);
    chk("bp_w2_count", 32'(dct_count), 32'd15);
    chk("carry_nodrop", 32'(drop_cnt), 32'd1);
    step(0, 2'b00, 1, 1, 0);
    chk("b2b_valid", 32'(dct_valid), 32'd1);
    chk("b2b_count", 32'(dct_count), 32'd1);
    chk("b2b_buf",   32'(dct_buffer), 32'h3);
    step(0, 2'b00, 0, 1, 0);
    chk("b2b_taken", 32'(dct_valid), 32'd0);
    step(0, 2'b00, 0, 1, 1);
    chk("drop_clr", 32'(drop_cnt), 32'd0);

    // 15th record coincides with acceptance of the previous word
    step(1, 2'b11, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0);
    chk("hold_a_count", 32'(dct_count), 32'd1);
    for (int i = 0; i < 14; i++) step(1, 2'b10, 0, 0, 0);
    chk("hold_a_stable", 32'(dct_buffer), 32'h3);
    step(1, 2'b10, 0, 1, 0);
    chk("coinc_count", 32'(dct_count), 32'd15);
    chk("coinc_buf",   32'(dct_buffer), 32'h2AAAAAAA);
    step(1, 2'b01, 0, 0, 0);
    chk("r16_nodrop", 32'(drop_cnt), 32'd0);
    chk("r16_held",   32'(dct_count), 32'd15);
    step(0, 2'b00, 1, 1, 0);
    chk("r16_count", 32'(dct_count), 32'd1);
    chk("r16_buf",   32'(dct_buffer), 32'h1);
    step(0, 2'b00, 0, 1, 0);

    // flush while output busy is latched until ready
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0);
    chk("pend_a_buf", 32'(dct_buffer), 32'h5);
    for (int i = 0; i < 7; i++) step(1, 2'b11, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0);
    chk("pend_held", 32'(dct_count), 32'd2);
    step(0, 2'b00, 0, 1, 0);
    chk("pend_count", 32'(dct_count), 32'd7);
    chk("pend_buf",   32'(dct_buffer), 32'h3FFF);
    step(0, 2'b00, 0, 1, 0);
    chk("pend_taken", 32'(dct_valid), 32'd0);

    // async reset with a held word and 7 buffered records
    step(1, 2'b10, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2'b01, 0, 0, 0);
    chk("pre_rst_valid", 32'(dct_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(dct_valid), 32'd0);
    chk("async_count", 32'(dct_count), 32'd0);
    chk("async_buf",   32'(dct_buffer), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    step(0, 2'b00, 1, 1, 0);
    chk("post_rst_flush", 32'(dct_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
